// File: rtl/arith_pkg.sv
// Shared arithmetic-unit types: divider state encoding and sizing helpers.
// Combinational only; no latency, no flow control.
package arith_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    DONE  = 2'd2,
    FIXUP = 2'd3
  } div_state_t;

  // Iteration counter width for a given operand width.
  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtract a - b as an inverted-operand ripple chain with carry-in 1.
// Latency: combinational. Backpressure: none.
module div_trial_sub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0]   c;
  logic [N-1:0] bn;

  assign bn   = ~b;
  assign c[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_ripple
      assign diff[i] = a[i] ^ bn[i] ^ c[i];
      assign c[i+1]  = (a[i] & bn[i]) | (c[i] & (a[i] ^ bn[i]));
    end
  endgenerate

  // No carry out of the top bit means a < b.
  assign borrow = ~c[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Restoring shift-and-subtract divider, one quotient bit per clock; SEQ_DIV_SIGNED_EN adds signed operands.
// Latency: done pulses WIDTH+1 edges after accept (WIDTH+2 signed), 1 edge for divide-by-zero.
// Backpressure: start is only honoured in IDLE; requests while busy or finishing are dropped.
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = div_cnt_width(WIDTH);

  div_state_t       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   pr;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             last;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH:0]   pr_nxt;
  logic [WIDTH-1:0] dvd_in;
  logic [WIDTH-1:0] dvs_in;

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q, neg_r;
  // The core only ever sees magnitudes; signs are reapplied in FIXUP.
  assign dvd_in = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_in = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign dvd_in = dividend;
  assign dvs_in = divisor;
`endif

  assign shifted = {pr[WIDTH-1:0], dq[WIDTH-1]};
  assign last    = (cnt == CW'(WIDTH - 1));
  assign q_nxt   = {dq[WIDTH-2:0], ~borrow};
  assign pr_nxt  = borrow ? shifted : trial;

  div_trial_sub #(.N(WIDTH + 1)) u_trial (
    .a      (shifted),
    .b      ({1'b0, dvs}),
    .diff   (trial),
    .borrow (borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
        if (last) state_nxt = FIXUP;
`else
        if (last) state_nxt = DONE;
`endif
      end
      FIXUP: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // done is registered off DONE so the pulse lands one edge after the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      cnt         <= '0;
      pr          <= '0;
      dq          <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          cnt <= '0;
          pr  <= '0;
          dq  <= dvd_in;
          dvs <= dvs_in;
`ifdef SEQ_DIV_SIGNED_EN
          neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r <= dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        CALC: begin
          pr  <= pr_nxt;
          dq  <= q_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            quotient    <= q_nxt;
            remainder   <= pr_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
`ifdef SEQ_DIV_SIGNED_EN
        FIXUP: begin
          if (neg_q) quotient  <= -quotient;
          if (neg_r) remainder <= -remainder;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomized and directed checks of seq_restoring_divider against a plain-arithmetic reference.
module tb_seq_restoring_divider;

  localparam int W = 8;
`ifdef SEQ_DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
      z = 1'b0;
    end
  endfunction

  // Issue one division and follow it to its done pulse; optionally pokes a
  // conflicting start while the division is in flight.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit inject);
    logic [W-1:0] eq, er;
    logic         ez;
    int           edges, bcyc;
    bit           got;
    ref_div(a, b, eq, er, ez);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    edges = 0; bcyc = 0; got = 0;
    while (!got && edges < 40) begin
      @(negedge clk);
      if (inject && edges == 2) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd9;
      end else begin
        start = 1'b0;
      end
      if (done) got = 1;
      else begin
        if (busy) bcyc++;
        @(posedge clk);
        edges++;
      end
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_lat"}, edges, (b == '0) ? 1 : LAT);
    check({tag, "_busy"}, bcyc, (b == '0) ? 0 : LAT - 1);
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] eq, er, prev_q;
    logic         ez;
    int           stray, cyc;
    logic [W-1:0] bb_a [4];
    logic [W-1:0] bb_b [4];

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_q", 32'(quotient), 0);
    check("rst_r", 32'(remainder), 0);
    check("rst_dbz", 32'(div_by_zero), 0);
    rst_n = 1'b1;

    run_div("d255_15", 8'd255, 8'd15, 0);

    // Reset in the middle of a division.
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_q", 32'(quotient), 0);
    check("midrst_r", 32'(remainder), 0);
    check("midrst_dbz", 32'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy || quotient != '0) stray++;
    end
    check("midrst_quiet", stray, 0);

    run_div("d200_7", 8'd200, 8'd7, 0);
    run_div("d13_200", 8'd13, 8'd200, 0);
    run_div("d255_1", 8'd255, 8'd1, 0);
    run_div("d77_0", 8'd77, 8'd0, 0);
    run_div("d10_3", 8'd10, 8'd3, 0);

    run_div("ign100_9", 8'd100, 8'd9, 1);
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    check("ign_nodone", stray, 0);

`ifdef SEQ_DIV_SIGNED_EN
    run_div("sm7_2", 8'hF9, 8'd2, 0);
    run_div("s7_m2", 8'd7, 8'hFE, 0);
    run_div("sm128_m1", 8'h80, 8'hFF, 0);
`endif

    // Start held high: each done is followed by acceptance on the next edge.
    bb_a[0] = 8'd91;  bb_b[0] = 8'd4;
    bb_a[1] = 8'd250; bb_b[1] = 8'd13;
    bb_a[2] = 8'd6;   bb_b[2] = 8'd6;
    bb_a[3] = 8'd129; bb_b[3] = 8'd2;
    prev_q = '0;
    @(negedge clk);
    start = 1'b1; dividend = bb_a[0]; divisor = bb_b[0];
    for (int k = 0; k < 4; k++) begin
      ref_div(bb_a[k], bb_b[k], eq, er, ez);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (k > 0 && cyc == 3) check("b2b_hold", 32'(quotient), 32'(prev_q));
      end while (!done && cyc < 40);
      check("b2b_done", 32'(done), 1);
      check("b2b_period", cyc, LAT + 1);
      check("b2b_q", 32'(quotient), 32'(eq));
      check("b2b_r", 32'(remainder), 32'(er));
      prev_q = eq;
      if (k < 3) begin
        dividend = bb_a[k+1]; divisor = bb_b[k+1];
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_div("rnd", ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
